// File: rtl/parallel_serial_tx.sv
// parallel_serial_tx: byte-to-serial transmitter, MSB first, one bit per clk_32f cycle.
// After reset it sends SYNC_COUNT comma symbols so the far-end receiver can lock, then
// accepts bytes through a valid/ready handshake, filling unused frames with a filler symbol.
// Optional feature macro: IDLE_SYMBOL_EN -- when defined, the ACTIVE-state filler is IDLE
// instead of COMMA (the sync preamble always uses COMMA).
module parallel_serial_tx #(
    parameter int          SYNC_COUNT = 4,
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter logic [7:0]  IDLE       = 8'h7C
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out
);

    // Wide enough to hold SYNC_COUNT itself (the count reached on the final SYNC load edge).
    localparam int SW = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT + 1) : 1;

`ifdef IDLE_SYMBOL_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif

    // Filler used once the preamble is complete.
    localparam logic [7:0] ACTIVE_FILL = IDLE_EN ? IDLE : COMMA;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [2:0]      bit_cnt_reg;
    logic [SW-1:0]   sync_cnt_reg;
    logic [SW-1:0]   sync_cnt_next;
    logic [7:0]      cur_byte_reg;
    logic [7:0]      cur_byte_next;
    logic            data_out_reg;
    logic            active_reg;

    logic            load;
    logic            last_sync;
    logic [7:0]      filler;

    // Frame-boundary decode and the handshake ready (combinational, low while in reset
    // because bit_cnt_reg is held at zero).
    always_comb begin
        load      = (bit_cnt_reg == 3'd7);
        last_sync = (sync_cnt_reg == SW'(SYNC_COUNT - 1));
        ready_out = load && ((state_reg == ACTIVE) || last_sync);
        filler    = (state_reg == ACTIVE) ? ACTIVE_FILL : COMMA;
    end

    // Next-state logic: choose the next symbol at each frame boundary and advance the
    // preamble counter / FSM while in SYNC.
    always_comb begin
        state_next    = state_reg;
        sync_cnt_next = sync_cnt_reg;
        cur_byte_next = cur_byte_reg;
        if (load) begin
            if (valid_in && ready_out) begin
                cur_byte_next = data_in;
            end else begin
                cur_byte_next = filler;
            end
            if (state_reg == SYNC) begin
                sync_cnt_next = sync_cnt_reg + SW'(1);
                if (last_sync) begin
                    state_next = ACTIVE;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_reg <= SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    // Serial datapath: shift out one bit per cycle and reload the symbol at frame end.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            bit_cnt_reg  <= 3'd0;
            sync_cnt_reg <= '0;
            cur_byte_reg <= COMMA;
            data_out_reg <= 1'b0;
            active_reg   <= 1'b0;
        end else begin
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            sync_cnt_reg <= sync_cnt_next;
            cur_byte_reg <= cur_byte_next;
            data_out_reg <= cur_byte_reg[3'd7 - bit_cnt_reg];
            active_reg   <= (state_next == ACTIVE);
        end
    end

    assign data_out   = data_out_reg;
    assign active_out = active_reg;

endmodule

// File: tb/tb_parallel_serial_tx.sv
// Testbench for parallel_serial_tx: randomized producer checked against a bit-queue
// reference model of the wire (frames of 8 bits, preamble of commas, filler on gaps).
module tb_parallel_serial_tx;

    localparam int         SC    = 4;
    localparam logic [7:0] COMMA = 8'hBC;
    localparam logic [7:0] IDLE  = 8'h7C;
`ifdef IDLE_SYMBOL_EN
    localparam logic [7:0] ACT_FILL = IDLE;
`else
    localparam logic [7:0] ACT_FILL = COMMA;
`endif

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       active_out;

    always #5 clk_32f = ~clk_32f;

    parallel_serial_tx #(
        .SYNC_COUNT(SC),
        .COMMA(COMMA),
        .IDLE(IDLE)
    ) dut (
        .clk_32f(clk_32f),
        .reset(reset),
        .data_in(data_in),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .data_out(data_out),
        .active_out(active_out)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: n = clock edges since reset release; exp_q = bits still due on the wire.
    int   n;
    bit   exp_q[$];
    logic obs_ready, exp_ready, obs_data, exp_data, obs_active, exp_active;
    bit   acc;

    task automatic push_frame(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    endtask

    task automatic model_reset();
        n = 0;
        exp_q.delete();
        push_frame(COMMA);
    endtask

    // Hold reset across two edges and release it at posedge+1 so the next edge is E1.
    task automatic do_reset();
        valid_in = 1'b0;
        reset    = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        model_reset();
        reset = 1'b1;
    endtask

    // One clock cycle: present inputs, sample ready before the edge, sample outputs after it,
    // and advance the model. Called at posedge+1, returns at posedge+1.
    task automatic tick(input logic v, input logic [7:0] d);
        int m;
        valid_in = v;
        data_in  = d;
        #3;
        m         = n + 1;
        obs_ready = ready_out;
        exp_ready = ((m % 8) == 0) && (m >= 8 * SC);
        acc       = exp_ready && v;
        @(posedge clk_32f);
        #1;
        n          = m;
        exp_data   = exp_q.pop_front();
        if ((m % 8) == 0) push_frame(acc ? d : ((m > 8 * SC) ? ACT_FILL : COMMA));
        obs_data   = data_out;
        obs_active = active_out;
        exp_active = (m >= 8 * SC);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'hFF;
        repeat (3) @(posedge clk_32f);
        #2;
        checks++;
        if (data_out !== 1'b0) begin failures++; $display("FAIL reset_data got=%b want=0", data_out); end
        checks++;
        if (ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready_out); end
        checks++;
        if (active_out !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", active_out); end
        $display("reset: data_out=%b ready_out=%b active_out=%b", data_out, ready_out, active_out);
        do_reset();
    endtask

    task automatic test_preamble();
        for (int i = 0; i < 48; i++) begin
            tick(1'b0, 8'h00);
            checks++;
            if (obs_ready !== exp_ready) begin failures++; $display("FAIL pre_ready edge=%0d got=%b want=%b", n, obs_ready, exp_ready); end
            checks++;
            if (obs_data !== exp_data) begin failures++; $display("FAIL pre_data edge=%0d got=%b want=%b", n, obs_data, exp_data); end
            checks++;
            if (obs_active !== exp_active) begin failures++; $display("FAIL pre_active edge=%0d got=%b want=%b", n, obs_active, exp_active); end
        end
        $display("preamble: 48 edges checked, active_out=%b", obs_active);
    endtask

    task automatic test_sync_hold();
        logic [7:0] pend;
        int first_acc;
        do_reset();
        pend      = 8'($urandom);
        first_acc = -1;
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, pend);
            if (acc && first_acc < 0) first_acc = n;
            checks++;
            if (obs_ready !== exp_ready) begin failures++; $display("FAIL hold_ready edge=%0d got=%b want=%b", n, obs_ready, exp_ready); end
            checks++;
            if (obs_data !== exp_data) begin failures++; $display("FAIL hold_data edge=%0d got=%b want=%b", n, obs_data, exp_data); end
            checks++;
            if (obs_active !== exp_active) begin failures++; $display("FAIL hold_active edge=%0d got=%b want=%b", n, obs_active, exp_active); end
            if (acc) begin
                $display("sync_hold: accepted %02h at edge %0d", pend, n);
                pend = 8'($urandom);
            end
        end
        $display("sync_hold: first accept at edge %0d", first_acc);
    endtask

    task automatic test_back_to_back();
        logic [7:0] list [4];
        logic [7:0] pend;
        int idx;
        list[0] = 8'hFF; list[1] = 8'hEE; list[2] = 8'hAA; list[3] = 8'hCC;
        idx  = 0;
        pend = list[0];
        for (int i = 0; i < 80; i++) begin
            tick(1'b1, pend);
            checks++;
            if (obs_ready !== exp_ready) begin failures++; $display("FAIL b2b_ready edge=%0d got=%b want=%b", n, obs_ready, exp_ready); end
            checks++;
            if (obs_data !== exp_data) begin failures++; $display("FAIL b2b_data edge=%0d got=%b want=%b", n, obs_data, exp_data); end
            if (acc) begin
                $display("back_to_back: accepted %02h at edge %0d", pend, n);
                idx++;
                pend = (idx < 4) ? list[idx] : 8'($urandom);
            end
        end
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 8'h00);
            checks++;
            if (obs_data !== exp_data) begin failures++; $display("FAIL b2b_drain edge=%0d got=%b want=%b", n, obs_data, exp_data); end
        end
    endtask

    task automatic test_gap();
        int phase;
        int gap_ticks;
        phase     = 0;
        gap_ticks = 0;
        for (int i = 0; i < 48; i++) begin
            case (phase)
                0: tick(1'b1, 8'h55);
                1: tick(1'b0, 8'h00);
                2: tick(1'b1, 8'h33);
                default: tick(1'b0, 8'h00);
            endcase
            checks++;
            if (obs_ready !== exp_ready) begin failures++; $display("FAIL gap_ready edge=%0d got=%b want=%b", n, obs_ready, exp_ready); end
            checks++;
            if (obs_data !== exp_data) begin failures++; $display("FAIL gap_data edge=%0d got=%b want=%b", n, obs_data, exp_data); end
            if (phase == 1) begin
                gap_ticks++;
                if (gap_ticks == 8) phase = 2;
            end else if (acc) begin
                $display("gap: accepted byte at edge %0d (phase %0d)", n, phase);
                phase++;
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pend;
        logic v;
        int naccs;
        v     = 1'b0;
        pend  = 8'h00;
        naccs = 0;
        for (int i = 0; i < 400; i++) begin
            if (!v) begin
                v    = 1'($urandom_range(0, 1));
                pend = 8'($urandom);
            end
            tick(v, pend);
            checks++;
            if (obs_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready edge=%0d got=%b want=%b", n, obs_ready, exp_ready); end
            checks++;
            if (obs_data !== exp_data) begin failures++; $display("FAIL rnd_data edge=%0d got=%b want=%b", n, obs_data, exp_data); end
            if (acc) begin
                naccs++;
                v = 1'b0;
            end
        end
        $display("random: %0d bytes accepted over 400 edges", naccs);
    endtask

    task automatic test_reset_midframe();
        int guard;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 16) begin
            tick(1'b1, 8'hAA);
            guard++;
        end
        checks++;
        if (!acc) begin failures++; $display("FAIL mid_accept got=0 want=1"); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00);
            checks++;
            if (obs_data !== exp_data) begin failures++; $display("FAIL mid_pre edge=%0d got=%b want=%b", n, obs_data, exp_data); end
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (data_out !== 1'b0) begin failures++; $display("FAIL mid_rst_data got=%b want=0", data_out); end
        checks++;
        if (ready_out !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b want=0", ready_out); end
        checks++;
        if (active_out !== 1'b0) begin failures++; $display("FAIL mid_rst_active got=%b want=0", active_out); end
        $display("reset_midframe: async reset data_out=%b ready_out=%b", data_out, ready_out);
        do_reset();
        for (int i = 0; i < 44; i++) begin
            tick(1'b0, 8'h00);
            checks++;
            if (obs_ready !== exp_ready) begin failures++; $display("FAIL mid_post_ready edge=%0d got=%b want=%b", n, obs_ready, exp_ready); end
            checks++;
            if (obs_data !== exp_data) begin failures++; $display("FAIL mid_post_data edge=%0d got=%b want=%b", n, obs_data, exp_data); end
            checks++;
            if (obs_active !== exp_active) begin failures++; $display("FAIL mid_post_active edge=%0d got=%b want=%b", n, obs_active, exp_active); end
        end
    endtask

    initial begin
        test_reset();
        test_preamble();
        test_sync_hold();
        test_back_to_back();
        test_gap();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
